// File: rtl/fabric_mgmt_mux_chan_adap_if.sv
// Signal bundle for the 2:1 stream mux: two input streams, one channelised output stream.
// The slave modport is the mux; the master modport is whatever feeds and drains it.
interface fabric_mgmt_mux_chan_adap_if #(
  parameter int DATA_WIDTH    = 8,
  parameter int CHANNEL_WIDTH = 1
);
  logic                     in0_valid;
  logic                     in0_startofpacket;
  logic                     in0_endofpacket;
  logic [DATA_WIDTH-1:0]    in0_data;
  logic                     in0_ready;
  logic                     in1_valid;
  logic                     in1_startofpacket;
  logic                     in1_endofpacket;
  logic [DATA_WIDTH-1:0]    in1_data;
  logic                     in1_ready;
  logic                     out_ready;
  logic                     out_valid;
  logic                     out_startofpacket;
  logic                     out_endofpacket;
  logic [DATA_WIDTH-1:0]    out_data;
  logic [CHANNEL_WIDTH-1:0] out_channel;

  modport slave (
    input  in0_valid, in0_startofpacket, in0_endofpacket, in0_data,
    input  in1_valid, in1_startofpacket, in1_endofpacket, in1_data,
    input  out_ready,
    output in0_ready, in1_ready,
    output out_valid, out_startofpacket, out_endofpacket, out_data, out_channel
  );

  modport master (
    output in0_valid, in0_startofpacket, in0_endofpacket, in0_data,
    output in1_valid, in1_startofpacket, in1_endofpacket, in1_data,
    output out_ready,
    input  in0_ready, in1_ready,
    input  out_valid, out_startofpacket, out_endofpacket, out_data, out_channel
  );
endinterface

// File: rtl/fabric_mgmt_mux_chan_adap.sv
// 2:1 round-robin stream mux with one registered output stage; the output channel names the source port.
// Define FABRIC_MGMT_MUX_PKT_LOCK_EN to hold the grant on one port from sop until that port's eop.
module fabric_mgmt_mux_chan_adap #(
  parameter int DATA_WIDTH    = 8,
  parameter int CHANNEL_WIDTH = 1
) (
  input  logic clk,
  input  logic reset,
  fabric_mgmt_mux_chan_adap_if.slave bus
);
  logic                     w_load_en;
  logic                     w_rr_grant;
  logic                     w_grant;
  logic                     w_acc;
  logic                     w_sop;
  logic                     w_eop;
  logic [DATA_WIDTH-1:0]    w_data;
  logic                     r_last;
  logic                     r_out_valid;
  logic                     r_out_sop;
  logic                     r_out_eop;
  logic [DATA_WIDTH-1:0]    r_out_data;
  logic [CHANNEL_WIDTH-1:0] r_out_channel;

  assign w_load_en    = !r_out_valid || bus.out_ready;
  // Readies are forced low during reset so nothing is consumed while the output stage is cleared.
  assign bus.in0_ready = !reset && w_load_en && !w_grant;
  assign bus.in1_ready = !reset && w_load_en &&  w_grant;
  assign w_acc  = (bus.in0_valid && bus.in0_ready) || (bus.in1_valid && bus.in1_ready);
  assign w_data = w_grant ? bus.in1_data : bus.in0_data;
  assign w_sop  = w_grant ? bus.in1_startofpacket : bus.in0_startofpacket;
  assign w_eop  = w_grant ? bus.in1_endofpacket   : bus.in0_endofpacket;

  // Round-robin choice: on contention favour the port not granted last.
  always_comb begin
    w_rr_grant = 1'b0;
    if (bus.in0_valid && bus.in1_valid) begin
      w_rr_grant = ~r_last;
    end else if (bus.in1_valid) begin
      w_rr_grant = 1'b1;
    end else begin
      w_rr_grant = 1'b0;
    end
  end

`ifdef FABRIC_MGMT_MUX_PKT_LOCK_EN
  typedef enum logic {ST_IDLE = 1'b0, ST_LOCKED = 1'b1} lock_state_t;
  lock_state_t r_state;
  lock_state_t w_state_nxt;
  logic        r_lock_port;
  logic        w_lock_port_nxt;

  // Lock state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_lock_port <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_lock_port <= w_lock_port_nxt;
    end
  end

  // Lock next-state: a multi-beat sop locks, eop from the locked port releases.
  always_comb begin
    w_state_nxt     = r_state;
    w_lock_port_nxt = r_lock_port;
    case (r_state)
      ST_IDLE: begin
        if (w_acc && w_sop && !w_eop) begin
          w_state_nxt     = ST_LOCKED;
          w_lock_port_nxt = w_grant;
        end else begin
          w_state_nxt     = ST_IDLE;
        end
      end
      ST_LOCKED: begin
        if (w_acc && w_eop) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_LOCKED;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Lock output: a locked port owns the grant even while it is idle.
  always_comb begin
    w_grant = w_rr_grant;
    case (r_state)
      ST_LOCKED: w_grant = r_lock_port;
      default:   w_grant = w_rr_grant;
    endcase
  end
`else
  assign w_grant = w_rr_grant;
`endif

  // Last-granted pointer; reset value 1 lets port 0 win the first contention.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last <= 1'b1;
    end else if (w_acc) begin
      r_last <= w_grant;
    end
  end

  // Output register stage: load when empty or draining, hold while stalled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_valid   <= 1'b0;
      r_out_sop     <= 1'b0;
      r_out_eop     <= 1'b0;
      r_out_data    <= '0;
      r_out_channel <= '0;
    end else if (w_load_en) begin
      r_out_valid <= w_acc;
      if (w_acc) begin
        r_out_sop     <= w_sop;
        r_out_eop     <= w_eop;
        r_out_data    <= w_data;
        r_out_channel <= CHANNEL_WIDTH'(w_grant);
      end
    end
  end

  assign bus.out_valid         = r_out_valid;
  assign bus.out_startofpacket = r_out_sop;
  assign bus.out_endofpacket   = r_out_eop;
  assign bus.out_data          = r_out_data;
  assign bus.out_channel       = r_out_channel;
endmodule

// File: doc/fabric_mgmt_mux_chan_adap.md
FABRIC_MGMT_MUX_CHAN_ADAP -- requirements
Module: fabric_mgmt_mux_chan_adap

Interface
REQ-001 SHALL have parameter: DATA_WIDTH, 8, payload width of every data port.
REQ-002 SHALL have parameter: CHANNEL_WIDTH, 1, out_channel width; input index k is emitted as channel value k.
REQ-003 SHALL have port: clk  in  1  single clock; all state on rising edge.
REQ-004 SHALL have port: reset  in  1  reset, asynchronous and active-high.
REQ-005 SHALL have ports: in0_valid, in0_startofpacket, in0_endofpacket  in  1 each  input 0 qualifiers.
REQ-006 SHALL have port: in0_data  in  DATA_WIDTH  input 0 payload.
REQ-007 SHALL have port: in0_ready  out  1  input 0 backpressure, combinational.
REQ-008 SHALL have ports: in1_valid, in1_startofpacket, in1_endofpacket  in  1 each; in1_data  in  DATA_WIDTH; in1_ready  out  1; input 1 counterparts.
REQ-009 SHALL have port: out_ready  in  1  downstream backpressure, readyLatency 0.
REQ-010 SHALL have ports: out_valid, out_startofpacket, out_endofpacket  out  1 each  registered.
REQ-011 SHALL have ports: out_data  out  DATA_WIDTH; out_channel  out  CHANNEL_WIDTH; both registered.

Function
REQ-012 SHALL contain one output register stage; load_en = !out_valid || out_ready.
REQ-013 SHALL transfer a beat on input k only when ink_valid && ink_ready; ink_ready = load_en && (grant == k).
REQ-014 SHALL register accepted beat's data, sop, eop and channel = k on the same edge; latency 1 cycle, throughput 1 beat/cycle.
REQ-015 SHALL clear out_valid on an edge where out_ready = 1 and no input beat is accepted.
REQ-016 SHALL hold all out_* stable while out_valid = 1 and out_ready = 0.
REQ-017 SHALL arbitrate round-robin: with both valid and unlocked, grant the port not granted last; with one valid, grant it.
REQ-018 SHALL update the last-granted pointer only on an accepted beat.
REQ-019 SHALL have lock state IDLE/LOCKED: IDLE -> LOCKED(k) on accepted beat with sop=1, eop=0; LOCKED(k) -> IDLE on accepted beat from k with eop=1.
REQ-020 SHALL, in LOCKED(k), grant only port k; other port's ready = 0 even if k is idle.
REQ-021 SHALL treat a beat with sop=1 and eop=1 as a single-beat packet; state stays IDLE.
REQ-022 SHALL, in LOCKED(k), accept a second sop without eop as a continuation beat (no error).
REQ-023 SHALL never assert both in0_ready and in1_ready in the same cycle.

Reset
REQ-024 SHALL, on reset assertion, immediately set out_valid=0, out_startofpacket=0, out_endofpacket=0, out_data=0, out_channel=0.
REQ-025 SHALL reset lock state to IDLE and the last-granted pointer to 1 (port 0 wins the first contention).
REQ-026 SHALL, on reset mid-packet, discard the held beat and lock; no beat is replayed after release.
REQ-027 SHALL drive in0_ready = in1_ready = 0 while reset is asserted.

Configuration
REQ-028 SHALL use macro FABRIC_MGMT_MUX_PKT_LOCK_EN.
REQ-029 SHALL, with the macro defined, implement the packet lock of REQ-019..REQ-022.
REQ-030 SHALL, without the macro, omit lock state; arbitration per beat (REQ-017), sop/eop forwarded unchanged.

Verification
REQ-031 SHALL cover: only in0 valid, data 0x11..0x14, out_ready=1 -> out_data 0x11..0x14 one cycle later, out_channel=0, one beat/cycle.
REQ-032 SHALL cover: both valid every cycle, single-beat packets (sop=eop=1), in0=0xA0, in1=0xB0 -> after reset out alternates channel 0,1,0,1.
REQ-033 SHALL cover (lock on): in0 3-beat packet 0x01,0x02,0x03 with in1 valid throughout -> channel 0 for all three, then in1 beat; in1_ready=0 during the packet.
REQ-034 SHALL cover: out_ready=0 for 4 cycles with out_valid=1 data 0x5A -> out_* stable, both in_ready=0; out_ready=1 -> 0x5A accepted, next beat follows.
REQ-035 SHALL cover: reset asserted after beat 2 of in1 4-beat packet -> out_valid=0 same cycle; after release, in0 single beat 0x77 granted, channel 0.
REQ-036 SHALL cover (lock off): same stimulus as REQ-033 -> channels interleave 0,1,0,1 per beat.
